nes_cpu_bus: RTL and testbench
==============================

NES_CPU_BUS -- requirements
Module: nes_cpu_bus

Interface
REQ-001 Parameter RAM_AW, default 11, work RAM address width (2 KiB).
REQ-002 Parameter TIMEOUT, default 255, maximum wait cycles for a PPU or PRG handshake.
REQ-003 clk  input  1  system clock; the design has one clock only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cpu_addr  input  16  CPU read address.
REQ-006 cpu_wraddr  input  16  CPU write (effective) address.
REQ-007 cpu_dout  input  8  CPU write data.
REQ-008 cpu_wreq  input  1  CPU write request, qualified by cpu_wraddr and cpu_dout.
REQ-009 cpu_din  output  8  read data returned to the CPU.
REQ-010 cpu_ce  output  1  one-cycle pulse; the CPU advances exactly one step per pulse.
REQ-011 ppu_reg  output  3  PPU register index.
REQ-012 ppu_wdata  output  8  PPU write data.
REQ-013 ppu_rd / ppu_wr  output  1 each  PPU access strobes; each is held high until acknowledged.
REQ-014 ppu_rdata  input  8  PPU read data.
REQ-015 ppu_ack  input  1  PPU access complete.
REQ-016 prg_addr  output  15  PRG ROM byte address.
REQ-017 prg_req  output  1  PRG read request; held high until prg_valid.
REQ-018 prg_rdata  input  8  PRG ROM data.
REQ-019 prg_valid  input  1  PRG data valid.
REQ-020 bus_err  output  1  sticky timeout flag; cleared only by reset.

Function
REQ-021 Address map:
- $0000-$1FFF: work RAM, mirrored by the low RAM_AW bits.
- $2000-$3FFF: PPU, register index = addr[2:0].
- $4000-$7FFF: open bus.
- $8000-$FFFF: PRG, prg_addr = addr[14:0].
REQ-022 FSM states: IDLE, WR_PPU, RD_RAM, RD_PPU, RD_PRG, DONE.
REQ-023 IDLE samples cpu_addr, cpu_wraddr, cpu_dout and cpu_wreq into registers; later phases use only the registered copies.
REQ-024 Write phase (when cpu_wreq is sampled) runs before the read phase:
- RAM target: written in the IDLE cycle itself.
- PPU target: WR_PPU with ppu_wr=1 until ppu_ack.
- PRG or open-bus target: write dropped, zero cycles.
REQ-025 Read phase:
- RAM: RD_RAM lasts exactly 1 cycle, covering synchronous RAM latency.
- PPU: RD_PPU with ppu_rd=1 until ppu_ack; data captured on the ack cycle.
- PRG: RD_PRG with prg_req=1 until prg_valid; data captured on the valid cycle.
- Open bus: straight to DONE; cpu_din keeps its previous value.
REQ-026 DONE drives cpu_ce=1 for exactly one cycle, then returns to IDLE.
REQ-027 cpu_din is updated only on read completion and is stable whenever cpu_ce=1.
REQ-028 Minimum access length, IDLE to DONE inclusive:
- RAM read: 3 cycles.
- Open-bus read: 2 cycles.
REQ-029 A single wait counter (8 bits minimum) counts cycles spent in WR_PPU, RD_PPU or RD_PRG and clears on state entry.
REQ-030 When the wait counter reaches TIMEOUT:
- the strobe drops;
- a read returns $FF;
- a write is abandoned;
- bus_err is set;
- the FSM proceeds as if the access completed.
REQ-031 ppu_ack arriving in the same cycle the timeout expires counts as a normal completion, not a timeout.
REQ-032 Outside WR_PPU, RD_PPU and RD_PRG:
- ppu_rd, ppu_wr and prg_req are 0;
- ppu_ack and prg_valid are ignored.
REQ-033 A write and a read to the same RAM address in one access return the newly written byte.

Reset
REQ-034 While rst is high, on each clk edge:
- FSM goes to IDLE;
- cpu_ce=0, cpu_din=$00;
- ppu_rd=0, ppu_wr=0, prg_req=0;
- ppu_reg=0, ppu_wdata=$00, prg_addr=0;
- wait counter=0, bus_err=0.
REQ-035 Reset asserted mid-access abandons the access with no cpu_ce pulse; strobes drop on the first reset edge.
REQ-036 Work RAM contents are not reset.

Structure
REQ-037 A shared package holds:
- state encoding;
- region base constants: RAM, PPU, OPEN, PRG;
- the open-bus/timeout data value $FF.
REQ-038 Work RAM is the single sub-module nes_wram: single-port synchronous, 2**RAM_AW x 8, write-first.

Verification
REQ-039 RAM write then read: write $A5 to $0801, then read $0001 (mirror) -> cpu_din=$A5; read access is 3 cycles; exactly one cpu_ce pulse per access.
REQ-040 PRG read of $C123, prg_valid after 5 cycles with $4C -> prg_addr=$4123, cpu_din=$4C, cpu_ce pulse one cycle after valid.
REQ-041 PPU write to $3FFE (ppu_ack after 2 cycles) plus read of $2002 in the same access -> ppu_wr with ppu_reg=6 first, then ppu_rd with ppu_reg=2, then cpu_ce.
REQ-042 PRG read with prg_valid never asserted -> prg_req drops after 255 cycles, cpu_din=$FF, bus_err=1 and held.
REQ-043 Read of $5000 after a read returning $37 -> cpu_din stays $37; access takes 2 cycles.
REQ-044 rst asserted during RD_PPU -> ppu_rd=0 on the next edge, no cpu_ce pulse, FSM back in IDLE, bus_err=0.

Source files
------------

// File: rtl/nes_cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nes_cpu_bus_pkg
//  Description : Shared types and constants for the NES CPU bus arbiter:
//                FSM state encoding, address-region decode and the data
//                value returned on open bus / timed-out reads.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package nes_cpu_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR_PPU = 3'd1,
      ST_RD_RAM = 3'd2,
      ST_RD_PPU = 3'd3,
      ST_RD_PRG = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      REGION_RAM  = 2'd0,
      REGION_PPU  = 2'd1,
      REGION_OPEN = 2'd2,
      REGION_PRG  = 2'd3
   } region_e;

   localparam logic [15:0] C_BASE_RAM  = 16'h0000;
   localparam logic [15:0] C_BASE_PPU  = 16'h2000;
   localparam logic [15:0] C_BASE_OPEN = 16'h4000;
   localparam logic [15:0] C_BASE_PRG  = 16'h8000;

   // Returned for open-bus reads that never had data, and for timed-out reads.
   localparam logic [7:0]  C_OPEN_BUS_DATA = 8'hFF;

   // Region boundaries all fall on power-of-two edges, so the top three
   // address bits are enough to classify an address.
   function automatic region_e decode_region(input logic [15:0] addr);
      region_e r;
      if (addr[15] == C_BASE_PRG[15])
         r = REGION_PRG;
      else if (addr[14] == C_BASE_OPEN[14])
         r = REGION_OPEN;
      else if (addr[15:13] == C_BASE_RAM[15:13])
         r = REGION_RAM;
      else if (addr[13] == C_BASE_PPU[13])
         r = REGION_PPU;
      else
         r = REGION_OPEN;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nes_wram.sv
`default_nettype none
// ============================================================================
//  Module      : nes_wram
//  Description : Single-port synchronous work RAM, 2**AW x 8, write-first
//                (a write also presents the written byte on rdata).
//                Contents are never reset.
//  Ports       : clk   - clock
//                en    - port enable; rdata only changes when en=1
//                we    - write enable (qualified by en)
//                addr  - word address
//                wdata - write data
//                rdata - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module nes_wram #(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem_q [0:(1<<AW)-1];
   logic [7:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[addr] <= wdata;
            rdata_q     <= wdata;
         end else begin
            rdata_q     <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/nes_cpu_bus.sv
`default_nettype none
// ============================================================================
//  Module      : nes_cpu_bus
//  Description : NES CPU bus sequencer. Each access samples the CPU request
//                in IDLE, performs an optional write (RAM / PPU) followed by
//                a read (RAM / PPU / PRG / open bus), then pulses cpu_ce for
//                one cycle in DONE. PPU and PRG handshakes are bounded by a
//                wait counter; an expired wait sets the sticky bus_err.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                cpu_addr/cpu_wraddr - CPU read / write address
//                cpu_dout, cpu_wreq  - CPU write data and request
//                cpu_din, cpu_ce     - read data and one-cycle step pulse
//                ppu_*               - PPU register port (strobes + ack)
//                prg_*               - PRG ROM read port (req + valid)
//                bus_err             - sticky handshake timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module nes_cpu_bus
   import nes_cpu_bus_pkg::*;
#(
   parameter int RAM_AW  = 11,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wraddr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_wreq,
   output logic [7:0]  cpu_din,
   output logic        cpu_ce,
   output logic [2:0]  ppu_reg,
   output logic [7:0]  ppu_wdata,
   output logic        ppu_rd,
   output logic        ppu_wr,
   input  logic [7:0]  ppu_rdata,
   input  logic        ppu_ack,
   output logic [14:0] prg_addr,
   output logic        prg_req,
   input  logic [7:0]  prg_rdata,
   input  logic        prg_valid,
   output logic        bus_err
);

   localparam int C_WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   // The wait counter starts at 0 on state entry, so the TIMEOUT-th cycle
   // spent waiting is the one where the counter holds TIMEOUT-1.
   localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [15:0]         addr_q, addr_d;
   logic [C_WAIT_W-1:0] wait_q, wait_d;
   logic [7:0]          cpu_din_q, cpu_din_d;
   logic [2:0]          ppu_reg_q, ppu_reg_d;
   logic [7:0]          ppu_wdata_q, ppu_wdata_d;
   logic [14:0]         prg_addr_q, prg_addr_d;
   logic                bus_err_q, bus_err_d;
   logic                ram_rd_q, ram_rd_d;

   logic                go_read;
   logic [15:0]         rd_addr;
   logic                wait_expired;
   logic                in_wait_state;

   logic                ram_en;
   logic                ram_we;
   logic [RAM_AW-1:0]   ram_addr;
   logic [7:0]          ram_rdata;

   // -------------------------------------------------------------------------
   // Work RAM: the write slot is the IDLE cycle (live CPU inputs), the read
   // slot is RD_RAM (registered address); read data appears in DONE.
   // -------------------------------------------------------------------------
   always_comb begin
      ram_we   = (state_q == ST_IDLE) && !rst && cpu_wreq &&
                 (decode_region(cpu_wraddr) == REGION_RAM);
      ram_en   = ram_we || (state_q == ST_RD_RAM);
      ram_addr = (state_q == ST_IDLE) ? cpu_wraddr[RAM_AW-1:0] : addr_q[RAM_AW-1:0];
   end

   nes_wram #(
      .AW (RAM_AW)
   ) u_wram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (cpu_dout),
      .rdata (ram_rdata)
   );

   // -------------------------------------------------------------------------
   // Next-state and datapath
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cpu_din_d   = cpu_din_q;
      ppu_reg_d   = ppu_reg_q;
      ppu_wdata_d = ppu_wdata_q;
      prg_addr_d  = prg_addr_q;
      bus_err_d   = bus_err_q;
      ram_rd_d    = (state_q == ST_RD_RAM);
      go_read     = 1'b0;
      rd_addr     = addr_q;
      wait_expired = (wait_q == C_WAIT_LAST);

      case (state_q)
         ST_IDLE: begin
            addr_d  = cpu_addr;
            rd_addr = cpu_addr;
            // RAM writes complete in this cycle; PRG / open-bus writes are
            // dropped, so only a PPU write adds a phase.
            if (cpu_wreq && (decode_region(cpu_wraddr) == REGION_PPU)) begin
               state_d     = ST_WR_PPU;
               ppu_reg_d   = cpu_wraddr[2:0];
               ppu_wdata_d = cpu_dout;
            end else begin
               go_read = 1'b1;
            end
         end

         ST_WR_PPU: begin
            // Ack wins over an expiry in the same cycle.
            if (ppu_ack) begin
               go_read = 1'b1;
            end else if (wait_expired) begin
               bus_err_d = 1'b1;
               go_read   = 1'b1;
            end
         end

         ST_RD_RAM: begin
            state_d = ST_DONE;
         end

         ST_RD_PPU: begin
            if (ppu_ack) begin
               cpu_din_d = ppu_rdata;
               state_d   = ST_DONE;
            end else if (wait_expired) begin
               cpu_din_d = C_OPEN_BUS_DATA;
               bus_err_d = 1'b1;
               state_d   = ST_DONE;
            end
         end

         ST_RD_PRG: begin
            if (prg_valid) begin
               cpu_din_d = prg_rdata;
               state_d   = ST_DONE;
            end else if (wait_expired) begin
               cpu_din_d = C_OPEN_BUS_DATA;
               bus_err_d = 1'b1;
               state_d   = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            // RAM data only arrives in DONE; latch it so it persists.
            if (ram_rd_q)
               cpu_din_d = ram_rdata;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Dispatch the read phase from either IDLE or the end of a PPU write.
      if (go_read) begin
         case (decode_region(rd_addr))
            REGION_RAM: begin
               state_d = ST_RD_RAM;
            end
            REGION_PPU: begin
               state_d   = ST_RD_PPU;
               ppu_reg_d = rd_addr[2:0];
            end
            REGION_PRG: begin
               state_d    = ST_RD_PRG;
               prg_addr_d = rd_addr[14:0];
            end
            default: begin
               state_d = ST_DONE;
            end
         endcase
      end

      in_wait_state = (state_q == ST_WR_PPU) || (state_q == ST_RD_PPU) ||
                      (state_q == ST_RD_PRG);
      if ((state_d != state_q) || !in_wait_state)
         wait_d = '0;
      else
         wait_d = wait_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wait_q      <= '0;
         cpu_din_q   <= '0;
         ppu_reg_q   <= '0;
         ppu_wdata_q <= '0;
         prg_addr_q  <= '0;
         bus_err_q   <= 1'b0;
         ram_rd_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wait_q      <= wait_d;
         cpu_din_q   <= cpu_din_d;
         ppu_reg_q   <= ppu_reg_d;
         ppu_wdata_q <= ppu_wdata_d;
         prg_addr_q  <= prg_addr_d;
         bus_err_q   <= bus_err_d;
         ram_rd_q    <= ram_rd_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs. Strobes decode from state so they fall on the same edge that
   // leaves the wait state (ack, expiry or reset).
   // -------------------------------------------------------------------------
   assign cpu_ce    = (state_q == ST_DONE);
   assign cpu_din   = ram_rd_q ? ram_rdata : cpu_din_q;
   assign ppu_wr    = (state_q == ST_WR_PPU);
   assign ppu_rd    = (state_q == ST_RD_PPU);
   assign prg_req   = (state_q == ST_RD_PRG);
   assign ppu_reg   = ppu_reg_q;
   assign ppu_wdata = ppu_wdata_q;
   assign prg_addr  = prg_addr_q;
   assign bus_err   = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_nes_cpu_bus.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nes_cpu_bus
//  Description : Directed self-checking bench for nes_cpu_bus. A background
//                responder answers PPU / PRG handshakes after a programmable
//                number of strobe cycles and logs what it observed.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nes_cpu_bus;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_addr, cpu_wraddr;
   logic [7:0]  cpu_dout;
   logic        cpu_wreq;
   logic [7:0]  cpu_din;
   logic        cpu_ce;
   logic [2:0]  ppu_reg;
   logic [7:0]  ppu_wdata;
   logic        ppu_rd, ppu_wr;
   logic [7:0]  ppu_rdata;
   logic        ppu_ack;
   logic [14:0] prg_addr;
   logic        prg_req;
   logic [7:0]  prg_rdata;
   logic        prg_valid;
   logic        bus_err;

   always #5 clk = ~clk;

   nes_cpu_bus #(
      .RAM_AW  (11),
      .TIMEOUT (255)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_addr   (cpu_addr),
      .cpu_wraddr (cpu_wraddr),
      .cpu_dout   (cpu_dout),
      .cpu_wreq   (cpu_wreq),
      .cpu_din    (cpu_din),
      .cpu_ce     (cpu_ce),
      .ppu_reg    (ppu_reg),
      .ppu_wdata  (ppu_wdata),
      .ppu_rd     (ppu_rd),
      .ppu_wr     (ppu_wr),
      .ppu_rdata  (ppu_rdata),
      .ppu_ack    (ppu_ack),
      .prg_addr   (prg_addr),
      .prg_req    (prg_req),
      .prg_rdata  (prg_rdata),
      .prg_valid  (prg_valid),
      .bus_err    (bus_err)
   );

   int total = 0;
   int bad   = 0;

   // Responder configuration (written by the main sequence only).
   int         ppu_lat = -1;   // ack in strobe cycle ppu_lat+1; -1 = never
   int         prg_lat = -1;
   logic [7:0] ppu_data = 8'h00;
   logic [7:0] prg_data = 8'h00;

   // Responder log (written by the responder only).
   int          tcyc = 0;
   int          wcnt = 0, rcnt = 0, pcnt = 0;
   int          last_wr_len = 0, last_rd_len = 0, last_prg_len = 0;
   int          wr_start = 0, rd_start = 0;
   logic [2:0]  last_wr_reg = '0, last_rd_reg = '0;
   logic [7:0]  last_wr_data = '0;
   logic [14:0] last_prg_addr = '0;

   initial begin
      ppu_ack   = 1'b0;
      prg_valid = 1'b0;
      ppu_rdata = 8'h00;
      prg_rdata = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         tcyc++;
         ppu_rdata = ppu_data;
         prg_rdata = prg_data;
         ppu_ack   = 1'b0;
         prg_valid = 1'b0;
         if (ppu_wr) begin
            if (wcnt == 0) wr_start = tcyc;
            wcnt++;
            last_wr_reg  = ppu_reg;
            last_wr_data = ppu_wdata;
            if (ppu_lat >= 0 && wcnt == ppu_lat + 1) ppu_ack = 1'b1;
         end else begin
            if (wcnt > 0) last_wr_len = wcnt;
            wcnt = 0;
         end
         if (ppu_rd) begin
            if (rcnt == 0) rd_start = tcyc;
            rcnt++;
            last_rd_reg = ppu_reg;
            if (ppu_lat >= 0 && rcnt == ppu_lat + 1) ppu_ack = 1'b1;
         end else begin
            if (rcnt > 0) last_rd_len = rcnt;
            rcnt = 0;
         end
         if (prg_req) begin
            pcnt++;
            last_prg_addr = prg_addr;
            if (prg_lat >= 0 && pcnt == prg_lat + 1) prg_valid = 1'b1;
         end else begin
            if (pcnt > 0) last_prg_len = pcnt;
            pcnt = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Call while the DUT is in an IDLE cycle. Returns the IDLE..DONE length
   // and the cpu_din seen during the cpu_ce pulse; leaves the DUT in IDLE.
   task automatic do_access(input logic wreq, input logic [15:0] wa,
                            input logic [7:0] wd, input logic [15:0] ra,
                            output int cyc, output logic [7:0] din);
      cpu_wreq   = wreq;
      cpu_wraddr = wa;
      cpu_dout   = wd;
      cpu_addr   = ra;
      cyc = 1;
      for (int i = 0; i < 600 && !cpu_ce; i++) begin
         tick();
         cyc++;
      end
      check("access_done", cpu_ce, 1);
      din = cpu_din;
      tick();
      check("ce_single_pulse", cpu_ce, 0);
      cpu_wreq = 1'b0;
      cpu_addr = 16'h5000;
   endtask

   int         cyc;
   logic [7:0] din;

   initial begin
      rst        = 1'b1;
      cpu_addr   = 16'h5000;
      cpu_wraddr = 16'h0000;
      cpu_dout   = 8'h00;
      cpu_wreq   = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_cpu_ce",    cpu_ce,    0);
      check("rst_cpu_din",   cpu_din,   8'h00);
      check("rst_ppu_rd",    ppu_rd,    0);
      check("rst_ppu_wr",    ppu_wr,    0);
      check("rst_prg_req",   prg_req,   0);
      check("rst_ppu_reg",   ppu_reg,   3'd0);
      check("rst_ppu_wdata", ppu_wdata, 8'h00);
      check("rst_prg_addr",  prg_addr,  15'h0000);
      check("rst_bus_err",   bus_err,   0);

      // RAM write + read of the same address in one access
      rst = 1'b0;
      do_access(1'b1, 16'h0801, 8'hA5, 16'h0801, cyc, din);
      check("ram_wr_rd_din", din, 8'hA5);
      check("ram_wr_rd_cyc", cyc, 3);
      // Mirror read
      do_access(1'b0, 16'h0000, 8'h00, 16'h0001, cyc, din);
      check("ram_mirror_din", din, 8'hA5);
      check("ram_mirror_cyc", cyc, 3);
      // Top-of-region write, mirrored read
      do_access(1'b1, 16'h1FFF, 8'h3C, 16'h07FF, cyc, din);
      check("ram_top_din", din, 8'h3C);
      check("ram_top_cyc", cyc, 3);

      // PRG read with valid after 5 cycles
      prg_lat  = 5;
      prg_data = 8'h4C;
      do_access(1'b0, 16'h0000, 8'h00, 16'hC123, cyc, din);
      check("prg_din",      din,           8'h4C);
      check("prg_cyc",      cyc,           8);
      check("prg_addr",     last_prg_addr, 15'h4123);
      check("prg_req_len",  last_prg_len,  6);
      check("prg_bus_err",  bus_err,       0);

      // PPU write to $3FFE then read of $2002, ack after 2 cycles each
      ppu_lat  = 2;
      ppu_data = 8'h9A;
      do_access(1'b1, 16'h3FFE, 8'h77, 16'h2002, cyc, din);
      check("ppu_din",      din,          8'h9A);
      check("ppu_cyc",      cyc,          8);
      check("ppu_wr_reg",   last_wr_reg,  3'd6);
      check("ppu_wr_data",  last_wr_data, 8'h77);
      check("ppu_wr_len",   last_wr_len,  3);
      check("ppu_rd_reg",   last_rd_reg,  3'd2);
      check("ppu_rd_len",   last_rd_len,  3);
      check("ppu_order",    (wr_start < rd_start), 1);

      // Open bus keeps the previous read value
      do_access(1'b1, 16'h0010, 8'h37, 16'h0010, cyc, din);
      check("ram_37_din", din, 8'h37);
      do_access(1'b0, 16'h0000, 8'h00, 16'h5000, cyc, din);
      check("open_din", din, 8'h37);
      check("open_cyc", cyc, 2);
      // PRG-targeted write is dropped at zero cost
      do_access(1'b1, 16'h9000, 8'hEE, 16'h6000, cyc, din);
      check("drop_wr_din", din, 8'h37);
      check("drop_wr_cyc", cyc, 2);

      // PRG timeout
      prg_lat = -1;
      do_access(1'b0, 16'h0000, 8'h00, 16'h8000, cyc, din);
      check("tmo_din",      din,          8'hFF);
      check("tmo_cyc",      cyc,          257);
      check("tmo_req_len",  last_prg_len, 255);
      check("tmo_bus_err",  bus_err,      1);
      do_access(1'b0, 16'h0000, 8'h00, 16'h4000, cyc, din);
      check("tmo_err_sticky", bus_err, 1);
      check("tmo_open_din",   din,     8'hFF);

      // Reset during RD_PPU
      ppu_lat  = -1;
      cpu_wreq = 1'b0;
      cpu_addr = 16'h2005;
      tick();
      check("midrst_ppu_rd_before", ppu_rd,  1);
      check("midrst_ppu_reg",       ppu_reg, 3'd5);
      tick();
      rst = 1'b1;
      tick();
      check("midrst_ppu_rd",  ppu_rd,  0);
      check("midrst_cpu_ce",  cpu_ce,  0);
      check("midrst_bus_err", bus_err, 0);
      check("midrst_ppu_reg0", ppu_reg, 3'd0);
      check("midrst_cpu_din", cpu_din, 8'h00);
      tick();
      check("midrst_cpu_ce2", cpu_ce, 0);
      rst = 1'b0;
      do_access(1'b0, 16'h0000, 8'h00, 16'h0801, cyc, din);
      check("post_rst_ram_din", din, 8'hA5);
      check("post_rst_ram_cyc", cyc, 3);

      // Ack coinciding with the last allowed wait cycle is a normal completion
      ppu_lat  = 254;
      ppu_data = 8'h5A;
      do_access(1'b0, 16'h0000, 8'h00, 16'h2007, cyc, din);
      check("edge_ack_din",     din,         8'h5A);
      check("edge_ack_cyc",     cyc,         257);
      check("edge_ack_rd_len",  last_rd_len, 255);
      check("edge_ack_bus_err", bus_err,     0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
